phys_free_list: RTL and testbench

- Circular FIFO of free physical register indices that feeds the rename stage.
- The rename stage pops one preg per renamed destination and writes it into the speculative RAT as the new mapping.
- The retirement RAT (RRF) pushes back the superseded preg on every committing instruction with rd != x0.
- On branch_flush, the speculative head rewinds to a retirement head pointer, so every preg allocated after the last commit returns to the list in the same cycle the RAT restores from the RRF.

---
 rtl/phys_free_list_pkg.sv | 13 +
 rtl/phys_free_list_if.sv | 24 ++
 rtl/phys_free_list.sv | 84 ++++++++
 tb/tb_phys_free_list.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/phys_free_list_pkg.sv
// Shared rename-side constants and types for the physical register free list.
// The RAT, RRF and ROB use the same preg index type.
package phys_free_list_pkg;

    localparam int NUM_PREGS      = 64;
    localparam int NUM_ARCH_REGS  = 32;
    localparam int PREG_IDX_WIDTH = $clog2(NUM_PREGS);
    localparam int FL_DEPTH       = NUM_PREGS - NUM_ARCH_REGS;
    localparam int PTR_WIDTH      = $clog2(FL_DEPTH);

    typedef logic [PREG_IDX_WIDTH-1:0] free_list_entry_t;

endpackage

// File: rtl/phys_free_list_if.sv
// Rename/commit-facing handshake of the free list.
// The master side is the rename/commit logic; the slave side is the free list.
interface phys_free_list_if;
    import phys_free_list_pkg::*;

    logic                 deq_en;
    free_list_entry_t     deq_preg;
    logic                 empty;
    logic                 enq_en;
    free_list_entry_t     enq_preg;
    logic                 branch_flush;
    logic [PTR_WIDTH:0]   free_count;

    modport master (
        output deq_en, enq_en, enq_preg, branch_flush,
        input  deq_preg, empty, free_count
    );

    modport slave (
        input  deq_en, enq_en, enq_preg, branch_flush,
        output deq_preg, empty, free_count
    );

endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical register indices. A retirement head tracks the
// committed allocation point so a branch flush can return all speculative pregs.
module phys_free_list
    import phys_free_list_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    phys_free_list_if.slave fl
);

    typedef logic [PTR_WIDTH:0] fl_ptr_t;

    if ((1 << PTR_WIDTH) != FL_DEPTH) begin : g_depth_check
        $error("phys_free_list: FL_DEPTH must be a power of two");
    end

    free_list_entry_t mem [FL_DEPTH];

    fl_ptr_t head, tail, retire_head;
    fl_ptr_t head_next, tail_next, retire_head_next;
    logic    full;
    logic    do_enq;
    logic    do_deq;

    function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
        return p + fl_ptr_t'(1);
    endfunction

    function automatic logic ptr_full(input fl_ptr_t h, input fl_ptr_t t);
        return (h[PTR_WIDTH-1:0] == t[PTR_WIDTH-1:0]) && (h[PTR_WIDTH] != t[PTR_WIDTH]);
    endfunction

    assign fl.empty      = (head == tail);
    assign full          = ptr_full(head, tail);
    assign fl.deq_preg   = mem[head[PTR_WIDTH-1:0]];
    assign fl.free_count = tail - head;

    // A flush overrides any dequeue, but a commit in the same cycle still lands.
    always_comb begin
        do_enq           = fl.enq_en && !full;
        do_deq           = fl.deq_en && !fl.empty && !fl.branch_flush;
        tail_next        = tail;
        retire_head_next = retire_head;
        head_next        = head;
        if (do_enq) begin
            tail_next        = ptr_inc(tail);
            retire_head_next = ptr_inc(retire_head);
        end
        if (fl.branch_flush) begin
            head_next = retire_head_next;
        end else if (do_deq) begin
            head_next = ptr_inc(head);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            retire_head <= '0;
            tail        <= {1'b1, {PTR_WIDTH{1'b0}}};
        end else begin
            head        <= head_next;
            retire_head <= retire_head_next;
            tail        <= tail_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem[i] <= free_list_entry_t'(NUM_ARCH_REGS + i);
            end
        end else if (do_enq) begin
            mem[tail[PTR_WIDTH-1:0]] <= fl.enq_preg;
        end
    end

    a_no_enq_full: assert property (@(posedge clk) disable iff (rst) fl.enq_en |-> !full);
    a_no_enq_x0:   assert property (@(posedge clk) disable iff (rst) fl.enq_en |-> (fl.enq_preg != '0));
    a_count_range: assert property (@(posedge clk) disable iff (rst) fl.free_count <= fl_ptr_t'(FL_DEPTH));
    a_retire_lag:  assert property (@(posedge clk) disable iff (rst)
                                    fl_ptr_t'(head - retire_head) <= fl_ptr_t'(FL_DEPTH));

endmodule

// File: tb/tb_phys_free_list.sv
// Scoreboard bench for phys_free_list: the driver queues expected post-edge state,
// a monitor compares it one time unit after each rising edge.
module tb_phys_free_list;
    import phys_free_list_pkg::*;

    typedef struct {
        free_list_entry_t   preg;
        logic               empty;
        logic [PTR_WIDTH:0] count;
        bit                 chk_preg;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    exp_t  exp_q  [$];
    string name_q [$];

    phys_free_list_if fl_if ();

    phys_free_list dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic r, input logic d, input logic e,
                                  input free_list_entry_t p, input logic f, input string name,
                                  input free_list_entry_t exp_preg, input logic exp_empty,
                                  input logic [PTR_WIDTH:0] exp_count, input bit chk_preg);
        exp_t x;
        @(negedge clk);
        rst                = r;
        fl_if.deq_en       = d;
        fl_if.enq_en       = e;
        fl_if.enq_preg     = p;
        fl_if.branch_flush = f;
        x.preg     = exp_preg;
        x.empty    = exp_empty;
        x.count    = exp_count;
        x.chk_preg = chk_preg;
        exp_q.push_back(x);
        name_q.push_back(name);
    endtask

    task automatic check_output();
        exp_t  x;
        string n;
        x = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (fl_if.empty !== x.empty) begin
            bad++;
            $display("[TB] FAIL %s empty: got %0b want %0b", n, fl_if.empty, x.empty);
        end
        total++;
        if (fl_if.free_count !== x.count) begin
            bad++;
            $display("[TB] FAIL %s free_count: got %0d want %0d", n, fl_if.free_count, x.count);
        end
        if (x.chk_preg) begin
            total++;
            if (fl_if.deq_preg !== x.preg) begin
                bad++;
                $display("[TB] FAIL %s deq_preg: got %0d want %0d", n, fl_if.deq_preg, x.preg);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check_output();
    end

    initial begin
        int wait_cycles;
        total = 0;
        bad   = 0;
        rst                = 1'b1;
        fl_if.deq_en       = 1'b0;
        fl_if.enq_en       = 1'b0;
        fl_if.enq_preg     = '0;
        fl_if.branch_flush = 1'b0;

        apply_stimulus(1, 0, 0, 0, 0, "reset", 32, 0, 32, 1);
        apply_stimulus(0, 1, 0, 0, 0, "deq1", 33, 0, 31, 1);
        apply_stimulus(0, 1, 0, 0, 0, "deq2", 34, 0, 30, 1);
        apply_stimulus(0, 1, 0, 0, 0, "deq3", 35, 0, 29, 1);

        // Reset in the middle of activity must restore the full list.
        apply_stimulus(1, 1, 0, 0, 0, "mid_reset", 32, 0, 32, 1);
        for (int i = 0; i < 32; i++) begin
            apply_stimulus(0, 1, 0, 0, 0, "drain",
                           free_list_entry_t'(33 + i), (i == 31),
                           (PTR_WIDTH+1)'(31 - i), (i < 31));
        end
        apply_stimulus(0, 1, 0, 0, 0, "deq_empty", 0, 1, 0, 0);
        apply_stimulus(0, 0, 1, 5, 0, "enq_on_empty", 5, 0, 1, 1);
        apply_stimulus(0, 0, 0, 0, 0, "hold", 5, 0, 1, 1);
        apply_stimulus(0, 1, 0, 0, 0, "deq_refill", 0, 1, 0, 0);

        apply_stimulus(1, 0, 0, 0, 0, "reset2", 32, 0, 32, 1);
        apply_stimulus(0, 1, 0, 0, 0, "f_deq1", 33, 0, 31, 1);
        apply_stimulus(0, 1, 0, 0, 0, "f_deq2", 34, 0, 30, 1);
        apply_stimulus(0, 1, 0, 0, 0, "f_deq3", 35, 0, 29, 1);
        apply_stimulus(0, 1, 0, 0, 0, "f_deq4", 36, 0, 28, 1);
        apply_stimulus(0, 0, 1, 3, 0, "f_commit", 36, 0, 29, 1);
        apply_stimulus(0, 0, 0, 0, 1, "flush", 33, 0, 32, 1);

        apply_stimulus(1, 0, 0, 0, 0, "reset3", 32, 0, 32, 1);
        apply_stimulus(0, 1, 0, 0, 0, "fe_deq1", 33, 0, 31, 1);
        apply_stimulus(0, 1, 0, 0, 0, "fe_deq2", 34, 0, 30, 1);
        apply_stimulus(0, 1, 1, 7, 1, "flush_enq", 33, 0, 32, 1);

        // Steady deq+enq: pregs pushed at step m reappear at step m+30.
        apply_stimulus(1, 0, 0, 0, 0, "reset4", 32, 0, 32, 1);
        apply_stimulus(0, 1, 0, 0, 0, "s_deq", 33, 0, 31, 1);
        for (int k = 1; k <= 40; k++) begin
            apply_stimulus(0, 1, 1, free_list_entry_t'(k), 0, "steady",
                           (k <= 30) ? free_list_entry_t'(33 + k) : free_list_entry_t'(k - 30),
                           0, 31, 1);
        end

        @(negedge clk);
        fl_if.deq_en = 1'b0;
        fl_if.enq_en = 1'b0;
        fl_if.branch_flush = 1'b0;

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_queue: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
